// File: rtl/arb_mux.sv
// arb_mux: N-channel arbitrating mux feeding a registered valid/ready output stage.
// Define ARB_MUX_FIXED_PRIO_EN for lowest-index-wins priority; default build is round-robin.
module arb_mux #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);
    localparam int PW = SEL_W + 1;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;

    logic [SEL_W-1:0]  base;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  grant_data;
    logic              load;
    logic              xfer;

`ifdef ARB_MUX_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    assign base = rr_ptr_q;

    // Explicit wrap so non-power-of-two channel counts never reach unused indices.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        logic [PW-1:0] pos;
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
        pos        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pos = {1'b0, base} + PW'(k);
            if (pos >= PW'(NUM_CH)) begin
                pos = pos - PW'(NUM_CH);
            end
            if (grant == '0 && in_valid[pos[SEL_W-1:0]]) begin
                grant[pos[SEL_W-1:0]] = 1'b1;
                grant_idx             = pos[SEL_W-1:0];
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant[k]) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign load = !out_valid_q || out_ready;
    assign xfer = load && (grant != '0);

    // A producer waiting while reset is asserted must not see an accept.
    assign in_ready = grant & {NUM_CH{load && !rst}};

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = grant_data;
                out_sel_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: vector table plus scoreboard on an 8-channel instance, and a 5-channel instance.
// Builds with or without ARB_MUX_FIXED_PRIO_EN; expectations follow the selected arbitration mode.
module tb_arb_mux;
    localparam int W  = 16;
    localparam int N  = 8;
    localparam int N5 = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data  = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_ready = 1'b0;

    logic [N5-1:0]   v5 = '0;
    logic [N5*W-1:0] d5 = '0;
    logic [N5-1:0]   rdy5;
    logic            ov5;
    logic [W-1:0]    od5;
    logic [2:0]      os5;
    logic            or5 = 1'b1;

    arb_mux #(.WIDTH(W), .NUM_CH(N)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(W), .NUM_CH(N5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in_data(d5), .in_ready(rdy5),
        .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(or5)
    );

    typedef struct {
        string      name;
        logic [7:0] v;
        logic       r;
        logic [7:0] exp_rdy;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  sel;
    } beat_t;

    beat_t       sb[$];
    int          errors = 0;
    int          checks = 0;
    logic        mv     = 1'b0;
    logic [N-1:0] pend  = '0;
    logic [15:0] chdata[N];
    logic [15:0] chdata5[N5];
    vec_t        vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One clock of main-instance stimulus; scoreboard and output-valid model advance with it.
    task automatic cycle(input string name, input logic [7:0] v, input logic r, input logic [7:0] exp_rdy);
        beat_t b;
        logic  load;
        b.data = '0;
        b.sel  = '0;
        in_valid  = v;
        out_ready = r;
        #1;
        if ((pend & ~v) != 0) begin
            checks++;
            errors++;
            $display("FAIL %s producer_rule: in_valid=%0h dropped pending %0h", name, v, pend);
        end
        pend = v & ~exp_rdy;
        chk({name, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (mv) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s scoreboard: beat %0h presented, none expected", name, out_data);
            end else begin
                chk({name, " out_data"}, 32'(out_data), 32'(sb[0].data));
                chk({name, " out_sel"}, 32'(out_sel), 32'(sb[0].sel));
                if (r) void'(sb.pop_front());
            end
        end
        load = !mv || r;
        if (load) begin
            if (exp_rdy != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (exp_rdy[i]) begin
                        b.data = chdata[i];
                        b.sel  = 3'(i);
                    end
                end
                sb.push_back(b);
                mv = 1'b1;
            end else begin
                mv = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk({name, " out_valid"}, 32'(out_valid), 32'(mv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] exp5;
        logic [2:0] sel5;

        for (int i = 0; i < N; i++) chdata[i] = 16'(16'hC000 + i * 16'h0111);
        chdata[3] = 16'hBEEF;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = chdata[i];
        for (int i = 0; i < N5; i++) begin
            chdata5[i]      = 16'(16'h5A00 + i);
            d5[i*W +: W]    = chdata5[i];
        end

        vecs[0] = '{"single",       8'h08, 1'b1, 8'h08};
        vecs[1] = '{"idle_drain",   8'h00, 1'b1, 8'h00};
        vecs[2] = '{"bp_load",      8'h03, 1'b0, 8'h01};
        vecs[3] = '{"bp_hold1",     8'h02, 1'b0, 8'h00};
        vecs[4] = '{"bp_hold2",     8'h02, 1'b0, 8'h00};
        vecs[5] = '{"drain_refill", 8'h02, 1'b1, 8'h02};
        vecs[6] = '{"wrap_to_7",    8'h80, 1'b1, 8'h80};

        @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_sel", 32'(out_sel), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) cycle(vecs[i].name, vecs[i].v, vecs[i].r, vecs[i].exp_rdy);

`ifndef ARB_MUX_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) cycle("rr_lap1", 8'hFF, 1'b1, 8'(1 << i));
        for (int i = 0; i < N; i++) cycle("rr_lap2", 8'hFF << i, 1'b1, 8'(1 << i));
`else
        for (int i = 0; i < N; i++) cycle("fixed_81", 8'h81, 1'b1, 8'h01);
        cycle("fixed_drop0", 8'h80, 1'b1, 8'h80);
`endif
        cycle("drain", 8'h00, 1'b1, 8'h00);

        cycle("pre_rst_load", 8'h08, 1'b0, 8'h08);
        cycle("pre_rst_hold", 8'h21, 1'b0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst out_valid", 32'(out_valid), 32'd0);
        chk("async_rst out_sel", 32'(out_sel), 32'd0);
        chk("async_rst out_data", 32'(out_data), 32'd0);
        chk("async_rst in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        mv   = 1'b0;
        pend = '0;
        @(negedge clk);
        rst = 1'b0;
        cycle("post_rst_ptr", 8'h21, 1'b1, 8'h01);
        cycle("post_rst_ch5", 8'h20, 1'b1, 8'h20);
        cycle("post_rst_drain", 8'h00, 1'b1, 8'h00);

        for (int i = 0; i < 9; i++) begin
            v5 = 5'h1F;
`ifndef ARB_MUX_FIXED_PRIO_EN
            exp5 = 5'(1 << (i % N5));
            sel5 = 3'(i % N5);
`else
            exp5 = 5'h01;
            sel5 = 3'd0;
`endif
            #1;
            chk("np2 in_ready", 32'(rdy5), 32'(exp5));
            @(posedge clk);
            @(negedge clk);
            chk("np2 out_valid", 32'(ov5), 32'd1);
            chk("np2 out_sel", 32'(os5), 32'(sel5));
            chk("np2 out_data", 32'(od5), 32'(chdata5[sel5]));
        end
        v5 = 5'h02;
        #1;
        chk("np2_ptr4_ch1 in_ready", 32'(rdy5), 32'h02);
        @(posedge clk);
        @(negedge clk);
        chk("np2_ptr4_ch1 out_sel", 32'(os5), 32'd1);
        v5 = '0;
        @(negedge clk);
        chk("np2_idle out_valid", 32'(ov5), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
